// File: rtl/mdu_seq.sv
// mdu_seq: iterative unsigned MULTU/DIVU sequencer that borrows the shared ALU
// for one add or subtract per cycle, leaving the result in HI/LO.
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 4'h0
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 4'h1
`endif
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            func,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            alu_req,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_x
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t          r_state, w_state_nx;
    logic [4:0]      r_cnt;
    logic            r_fn, r_done;
    logic [XLEN-1:0] r_opb, r_hi, r_lo, w_hi_nx, w_lo_nx, w_r;
    logic            w_run, w_last, w_carry, w_nb;
    assign w_run   = r_state == RUN;
    assign w_last  = w_run && r_cnt == 5'(XLEN - 1);
    assign w_r     = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
    // ALU operands decode only from registered state, so alu_x never loops back into them
    assign alu_op  = (w_run && r_fn) ? `ALU_OP_SUB : `ALU_OP_ADD;
    assign alu_a   = !w_run ? '0 : (r_fn ? w_r : r_hi);
    assign alu_b   = w_run ? r_opb : '0;
    assign busy    = w_run;
    assign alu_req = w_run;
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end
    always_comb begin
        w_state_nx = r_state;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_carry    = alu_x < r_hi;
        w_nb       = r_hi[XLEN-1] | (alu_x <= w_r);
        if (!w_run) begin
            if (start) begin
                w_state_nx = RUN;
                w_hi_nx    = '0;
                w_lo_nx    = rs;
            end
        end else begin
            if (!r_fn)
                {w_hi_nx, w_lo_nx} = r_lo[0] ? {w_carry, alu_x, r_lo[XLEN-1:1]}
                                             : {1'b0, r_hi, r_lo[XLEN-1:1]};
            else begin
                w_hi_nx = w_nb ? alu_x : w_r;
                w_lo_nx = {r_lo[XLEN-2:0], w_nb};
            end
            if (w_last) w_state_nx = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_fn   <= 1'b0;
            r_opb  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_hi   <= w_hi_nx;
            r_lo   <= w_lo_nx;
            r_done <= w_last;
            r_cnt  <= w_run ? r_cnt + 5'd1 : 5'd0;
            if (!w_run && start) begin
                r_fn  <= func;
                r_opb <= rt;
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq; a behavioural ALU closes the borrowed
// datapath and HI/LO are checked against native 64-bit multiply / divide.
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 4'h0
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 4'h1
`endif
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, func;
    logic [31:0] rs, rt, hi, lo, alu_a, alu_b, alu_x;
    logic        busy, done, alu_req;
    logic [3:0]  alu_op;
    logic [63:0] sb[$];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign alu_x = (alu_op == `ALU_OP_SUB) ? alu_a - alu_b : alu_a + alu_b;

    mdu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_req(alu_req),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x)
    );

    function automatic logic [63:0] model(input logic f, input logic [31:0] a, input logic [31:0] b);
        if (!f)     return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else                chk("hilo", {hi, lo}, sb.pop_front());
        end
    end

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n && done && prev_done) chk("done_single_pulse", 64'd1, 64'd0);
        prev_done <= done;
    end

    task automatic wait_done(input bit timing, input logic f);
        int n = 0, nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (timing && n == 1) begin
                chk("alu_req_run", {63'd0, alu_req}, 64'd1);
                chk("alu_op_run", {60'd0, alu_op}, {60'd0, f ? `ALU_OP_SUB : `ALU_OP_ADD});
            end
        end while (!done && n < 60);
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        else if (timing) begin
            chk("done_latency", 64'(n), 64'd33);
            chk("busy_cycles", 64'(nb), 64'd32);
        end
    endtask

    task automatic issue(input logic f, input logic [31:0] a, input logic [31:0] b);
        sb.push_back(model(f, a, b));
        start = 1'b1; func = f; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0; func = $urandom; rs = $urandom; rt = $urandom;
    endtask

    task automatic run_op(input logic f, input logic [31:0] a, input logic [31:0] b);
        issue(f, a, b);
        wait_done(1'b1, f);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; func = 1'b0; rs = '0; rt = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy_done_req", {61'd0, busy, done, alu_req}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_alu", {alu_op, alu_a, alu_b}, {`ALU_OP_ADD, 64'd0});
        rst_n = 1'b1;
        run_op(1'b0, 32'd7, 32'd6);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(1'b1, 32'd100, 32'd7);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b1, 32'h1234, 32'd0);
        repeat (3) @(negedge clk);
        chk("hilo_hold", {hi, lo}, model(1'b1, 32'h1234, 32'd0));
        chk("idle_alu", {alu_op, alu_a, alu_b}, {`ALU_OP_ADD, 64'd0});
        // start during RUN must be dropped: no scoreboard entry, so an extra done would fail
        issue(1'b0, 32'h0001_2345, 32'h0000_0ABC);
        repeat (10) @(negedge clk);
        start = 1'b1; func = 1'b1; rs = 32'd99; rt = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, 1'b0);
        // we sit in the done cycle here, so this start is accepted immediately
        run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_1003);
        issue(1'b0, 32'hCAFE_F00D, 32'h1357_9BDF);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", {61'd0, busy, done, alu_req}, 64'd0);
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'd3, 32'd5);
        for (int i = 0; i < 24; i++) begin
            logic        f;
            logic [31:0] a, b;
            f = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(f, a, b);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative unsigned multiply/divide sequencer that borrows the shared 32-bit ALU for one add or subtract per cycle, instead of instantiating its own adder. It sits beside the execute stage. While `alu_req` is high, the execute-stage ALU operand mux selects this block's `alu_op`/`alu_a`/`alu_b`, and the ALU's `x` returns on `alu_x`. The block implements MULTU and DIVU into HI/LO registers, 32 iterations each.

## Interface
Parameters:
- `XLEN`, 32, operand width; iteration count equals `XLEN`; only 32 is supported.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when not busy.
- `func` in 1: 0 = MULTU, 1 = DIVU.
- `rs` in 32: multiplicand / dividend.
- `rt` in 32: multiplier / divisor.
- `busy` out 1: high while iterating.
- `done` out 1: one-cycle pulse; HI/LO valid.
- `hi` out 32: product[63:32] / remainder.
- `lo` out 32: product[31:0] / quotient.
- `alu_req` out 1: ALU ownership request; equals `busy`.
- `alu_op` out 4: ALU opcode (`ALU_OP_ADD` or `ALU_OP_SUB` defines).
- `alu_a` out 32: ALU operand a.
- `alu_b` out 32: ALU operand b.
- `alu_x` in 32: ALU result, combinational from `alu_op`/`alu_a`/`alu_b` in the same cycle.

## Operation
Clock is `clk`; reset is asynchronous and active-low on `rst_n`.

Registers: state {IDLE, RUN}, `cnt` (5-bit), `fn`, `opb` (latched `rt`), `hi`, `lo`, `done`.

Reset value of every output is 0. State IDLE, cnt 0, hi/lo 0, done 0. ALU outputs: `alu_op`=`ALU_OP_ADD`, `alu_a`=0, `alu_b`=0.

**IDLE:**
- On `start`: latch `fn`=`func` and `opb`=`rt`.
- MULTU: `hi`=0, `lo`=`rs`. DIVU: `hi`=0, `lo`=`rs`.
- `cnt`=0; go to RUN.

**RUN, MULTU (shift-add), one step per cycle:**
- `alu_op`=ADD, `alu_a`=`hi`, `alu_b`=`opb`.
- If `lo[0]`: carry = (`alu_x` < `hi`), and {hi,lo} <= {carry, alu_x, lo[31:1]}.
- Else: {hi,lo} <= {1'b0, hi, lo[31:1]}.

**RUN, DIVU (restoring), one step per cycle:**
- Shifted remainder: r = {hi[30:0], lo[31]}, with top bit t = hi[31].
- `alu_op`=SUB, `alu_a`=r, `alu_b`=`opb`.
- No-borrow: nb = t | (`alu_x` <= r).
- If nb: hi <= alu_x and lo <= {lo[30:0],1}.
- Else: hi <= r and lo <= {lo[30:0],0}.

**Termination and control:**
- `cnt` increments each RUN cycle. The step executed at `cnt`==31 sets `done` and returns to IDLE.
- The `done` register clears on the next edge unless it is set again.
- `start` while in RUN is ignored; there is no queueing.
- `start` in the cycle where `done`=1 is accepted normally, since the state is IDLE.
- `hi`/`lo` hold their value from completion until the next accepted `start`.

**Divide by zero:** no special case. The algorithm yields `lo`=FFFFFFFF and `hi`=dividend.

**ALU outputs in IDLE:** ADD/0/0. The ALU outputs are combinational decodes of state, `fn`, `hi`, `lo` and `opb`.

## Timing
- Accepting edge E: `start`=1 in IDLE sampled at E. From E, `busy`/`alu_req` are high.
- Steps execute at edges E+1 through E+32. At E+32, `busy` falls and `done` rises.
- `done` is high for exactly the cycle after E+32. Results are valid at E+32.
- Back-to-back throughput is one operation per 33 cycles.
- `alu_x` must settle within the same cycle. The ALU path is combinational and has no pipeline register.
- Reset asserted mid-RUN takes effect immediately: IDLE, `busy`/`done` 0, `hi`/`lo` 0. The partial result is discarded.
- After `rst_n` deasserts, the first `start` is accepted at the next edge.

## Test plan
- MULTU rs=7, rt=6 -> `done` 32 cycles after the accepting edge; hi=00000000, lo=0000002A; `busy` high exactly 32 cycles.
- MULTU rs=FFFFFFFF, rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001 (exercises the carry path every step).
- DIVU rs=100, rt=7 -> lo=14, hi=2. Also DIVU rs=80000000, rt=FFFFFFFF -> lo=0, hi=80000000.
- DIVU rs=1234, rt=0 -> lo=FFFFFFFF, hi=00001234, no hang, `done` pulses once.
- Second `start` with different operands at step 10 of a MULTU -> ignored, first result correct. A `start` issued in the `done` cycle -> accepted, new result after 32 more cycles.
- Assert `rst_n`=0 asynchronously at step 10 -> `busy`, `done`, `hi`, `lo`, `alu_req` go to 0 at once. After release, MULTU 3x5 -> lo=0000000F.
